sr_cmd_gen: RTL and testbench



---
 rtl/sr_cmd_gen.sv | 136 +++++++++++++
 tb/tb_sr_cmd_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// Command stage for sr_ff: synchronizes and debounces two buttons and turns
// their rising edges into spaced, mutually exclusive one-cycle s/r pulses.
module sr_cmd_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic reset_btn,
    output logic s,
    output logic r,
    output logic conflict,
    output logic set_level,
    output logic reset_level
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic {
        IDLE,
        GAP
    } state_t;

    // Channel 0 is set, channel 1 is reset.
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [DW-1:0]          deb_q  [2];
    logic [1:0]             raw;
    logic [1:0]             synced;
    logic [1:0]             lvl_q;
    logic [1:0]             lvl_prev_q;
    logic [1:0]             ev;
    logic [1:0]             req;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [1:0]    pend_q, pend_d;
    logic          s_d, r_d, conf_d;

    assign raw    = {reset_btn, set_btn};
    assign synced = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
    assign ev     = lvl_q & ~lvl_prev_q;
    assign req    = ev | pend_q;

    assign set_level   = lvl_q[0];
    assign reset_level = lvl_q[1];

    // Synchronize each raw button, then debounce it into a stable level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                sync_q[c] <= '0;
                deb_q[c]  <= '0;
            end
            lvl_q      <= '0;
            lvl_prev_q <= '0;
        end else begin
            lvl_prev_q <= lvl_q;
            for (int c = 0; c < 2; c++) begin
                sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], raw[c]};
                if (synced[c] != lvl_q[c]) begin
                    if (deb_q[c] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        lvl_q[c] <= synced[c];
                        deb_q[c] <= '0;
                    end else begin
                        deb_q[c] <= deb_q[c] + DW'(1);
                    end
                end else begin
                    deb_q[c] <= '0;
                end
            end
        end
    end

    // FSM state, gap counter, pending requests and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            pend_q   <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            s        <= s_d;
            r        <= r_d;
            conflict <= conf_d;
        end
    end

    // Issue in IDLE with reset priority; queue events that land in GAP.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pend_d  = pend_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        conf_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req[1]) begin
                    r_d     = 1'b1;
                    conf_d  = req[0];
                    pend_d  = '0;
                    state_d = GAP;
                    gap_d   = GW'(GAP_CYCLES);
                end else if (req[0]) begin
                    s_d     = 1'b1;
                    pend_d  = '0;
                    state_d = GAP;
                    gap_d   = GW'(GAP_CYCLES);
                end
            end
            GAP: begin
                pend_d = pend_q | ev;
                if (gap_q <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
                pend_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed self-checking bench for sr_cmd_gen with default parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_sr_cmd_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic set_btn = 1'b0;
    logic reset_btn = 1'b0;
    logic s, r, conflict, set_level, reset_level;

    int total = 0;
    int bad   = 0;
    int ns = 0, nr = 0, nc = 0;
    int bs = 0, br = 0, bc = 0;

    sr_cmd_gen dut (
        .clk         (clk),
        .rst         (rst),
        .set_btn     (set_btn),
        .reset_btn   (reset_btn),
        .s           (s),
        .r           (r),
        .conflict    (conflict),
        .set_level   (set_level),
        .reset_level (reset_level)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle; each one-cycle pulse counts once.
    always @(negedge clk) begin
        if (s === 1'b1) ns++;
        if (r === 1'b1) nr++;
        if (conflict === 1'b1) nc++;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        bs = ns;
        br = nr;
        bc = nc;
    endtask

    task automatic outs0(input string tag);
        chk({tag, "_s"}, s, 1'b0);
        chk({tag, "_r"}, r, 1'b0);
        chk({tag, "_conflict"}, conflict, 1'b0);
        chk({tag, "_set_level"}, set_level, 1'b0);
        chk({tag, "_reset_level"}, reset_level, 1'b0);
    endtask

    initial begin
        // Reset asserted mid-cycle clears outputs before the next edge.
        tick();
        tick();
        #3 rst = 1'b1;
        #1 outs0("rst_async");
        for (int i = 0; i < 5; i++) begin
            tick();
            outs0("rst_hold");
        end
        rst = 1'b0;
        tick();
        tick();
        outs0("post_rst");

        // Clean set: level after edge k+5, s only after edge k+6.
        mark();
        set_btn = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("clean_level", set_level, i >= 6);
            chk("clean_s", s, i == 7);
            chk("clean_r", r, 1'b0);
            chk("clean_conflict", conflict, 1'b0);
        end
        set_btn = 1'b0;
        repeat (15) tick();
        chk("clean_level_fall", set_level, 1'b0);
        chki("clean_s_count", ns - bs, 1);
        chki("clean_r_count", nr - br, 0);

        // Glitch shorter than the debounce window.
        mark();
        set_btn = 1'b1;
        repeat (3) tick();
        set_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("glitch_level", set_level, 1'b0);
        end
        chki("glitch_s_count", ns - bs, 0);

        // Simultaneous presses: reset wins and conflict flags it.
        mark();
        set_btn   = 1'b1;
        reset_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("simul_r", r, i == 7);
            chk("simul_conflict", conflict, i == 7);
            chk("simul_s", s, 1'b0);
        end
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        repeat (15) tick();
        chki("simul_r_count", nr - br, 1);
        chki("simul_c_count", nc - bc, 1);
        chki("simul_s_count", ns - bs, 0);

        // Hold-off: reset one cycle after set issues 4 edges after s.
        mark();
        set_btn = 1'b1;
        tick();
        reset_btn = 1'b1;
        for (int i = 2; i <= 13; i++) begin
            tick();
            chk("hold_s", s, i == 7);
            chk("hold_r", r, i == 11);
            chk("hold_conflict", conflict, 1'b0);
        end
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        repeat (15) tick();
        chki("hold_s_count", ns - bs, 1);
        chki("hold_r_count", nr - br, 1);
        chki("hold_c_count", nc - bc, 0);

        // Reset during GAP drops the pending reset request.
        mark();
        set_btn = 1'b1;
        tick();
        reset_btn = 1'b1;
        for (int i = 2; i <= 7; i++) begin
            tick();
            chk("midgap_s", s, i == 7);
        end
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        tick();
        #3 rst = 1'b1;
        #1 outs0("midgap_rst");
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("midgap_r", r, 1'b0);
        end
        outs0("midgap_after");
        chki("midgap_r_count", nr - br, 0);
        chki("midgap_c_count", nc - bc, 0);

        // FSM back in IDLE: a fresh press has the nominal latency.
        mark();
        set_btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("idle_s", s, i == 7);
        end
        set_btn = 1'b0;
        repeat (15) tick();
        chki("idle_s_count", ns - bs, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
